// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//  - funct3 encodings for the access sizes
//  - FSM state encoding
//  - writeback exception codes
//  - helpers that classify an access as illegal or misaligned
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering for the load/store unit (32-bit bus, 4 lanes).
//  Store side: st_funct3/st_addr_lo/st_data -> st_be (byte enables) and st_wdata
//              (store data replicated into every lane so the enabled lane carries it).
//  Load side:  ld_funct3/ld_addr_lo/ld_rdata -> ld_data (selected lane, sign- or
//              zero-extended; W passes the word through).
module lsu_data_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      st_be,
    output logic [XLEN-1:0] st_wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // funct3[1:0] gives the size; stores only reach here with B/H/W.
            assign st_wdata[gi*8 +: 8] = (st_funct3[1:0] == 2'b00) ? st_data[7:0] :
                                         (st_funct3[1:0] == 2'b01) ? st_data[(gi%2)*8 +: 8] :
                                                                     st_data[gi*8 +: 8];
            assign rd_byte[gi] = ld_rdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        st_be = 4'b1111;
        case (st_funct3[1:0])
            2'b00:   st_be = 4'b0001 << st_addr_lo;
            2'b01:   st_be = 4'b0011 << st_addr_lo;
            default: st_be = 4'b1111;
        endcase
    end

    assign byte_sel = rd_byte[ld_addr_lo];
    assign half_sel = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
//  EX side:  ex_valid/ex_alu_result/ex_store_data/ex_funct3/ex_mem_read/ex_mem_write/ex_rd in,
//            ex_stall out (high whenever a bus transaction is in flight).
//  Bus side: mem_req/mem_we/mem_addr/mem_be/mem_wdata out, mem_gnt/mem_rvalid/mem_rdata in.
//  WB side:  wb_valid (1-cycle pulse), wb_we, wb_rd, wb_data, exc_code.
// Faulting accesses (illegal funct3, misaligned) never reach the bus; they report the
// faulting address in wb_data. A bus transaction that does not finish within MAX_WAIT
// cycles in REQ+WAIT_RSP is abandoned with a timeout code.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [4:0]      ex_rd,
    output logic            ex_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      exc_code
);

    // One extra count of headroom: a load granted on the last allowed REQ cycle
    // enters WAIT_RSP with the counter at MAX_WAIT.
    localparam int CW = $clog2(MAX_WAIT + 2);

    lsu_state_t      state_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic [XLEN-1:0] req_addr_reg;
    logic [2:0]      req_funct3_reg;
    logic [4:0]      req_rd_reg;
    logic            mem_req_reg, mem_we_reg;
    logic [XLEN-1:0] mem_addr_reg, mem_wdata_reg;
    logic [3:0]      mem_be_reg;
    logic            wb_valid_reg, wb_we_reg;
    logic [4:0]      wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic [1:0]      exc_code_reg;

    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata, ld_data;
    logic            is_mem_op, wait_last;

    lsu_data_align #(.XLEN(XLEN)) u_align (
        .st_funct3  (ex_funct3),
        .st_addr_lo (ex_alu_result[1:0]),
        .st_data    (ex_store_data),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_funct3  (req_funct3_reg),
        .ld_addr_lo (req_addr_reg[1:0]),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

    assign is_mem_op = ex_mem_read | ex_mem_write;
    // True in the MAX_WAIT-th cycle spent in REQ/WAIT_RSP (counter starts at 0).
    assign wait_last = (wait_cnt_reg >= CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            req_addr_reg   <= '0;
            req_funct3_reg <= '0;
            req_rd_reg     <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_be_reg     <= '0;
            mem_wdata_reg  <= '0;
            wb_valid_reg   <= 1'b0;
            wb_we_reg      <= 1'b0;
            wb_rd_reg      <= '0;
            wb_data_reg    <= '0;
            exc_code_reg   <= EXC_NONE;
        end else begin
            wb_valid_reg <= 1'b0;
            exc_code_reg <= EXC_NONE;
            case (state_reg)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem_op) begin
                            wb_valid_reg <= 1'b1;
                            wb_we_reg    <= (ex_rd != 5'd0);
                            wb_rd_reg    <= ex_rd;
                            wb_data_reg  <= ex_alu_result;
                        end else if (!funct3_legal(ex_funct3, ex_mem_write) ||
                                     addr_misaligned(ex_funct3, ex_alu_result[1:0])) begin
                            wb_valid_reg <= 1'b1;
                            wb_we_reg    <= 1'b0;
                            wb_rd_reg    <= ex_rd;
                            wb_data_reg  <= ex_alu_result;
                            exc_code_reg <= funct3_legal(ex_funct3, ex_mem_write) ?
                                            EXC_MISALIGN : EXC_ILLEGAL;
                        end else begin
                            state_reg      <= REQ;
                            wait_cnt_reg   <= '0;
                            req_addr_reg   <= ex_alu_result;
                            req_funct3_reg <= ex_funct3;
                            req_rd_reg     <= ex_rd;
                            mem_req_reg    <= 1'b1;
                            mem_we_reg     <= ex_mem_write;
                            mem_addr_reg   <= {ex_alu_result[XLEN-1:2], 2'b00};
                            mem_be_reg     <= st_be;
                            mem_wdata_reg  <= st_wdata;
                        end
                    end
                end
                REQ: begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    if (mem_gnt) begin
                        mem_req_reg <= 1'b0;
                        if (mem_we_reg) begin
                            state_reg    <= IDLE;
                            wb_valid_reg <= 1'b1;
                            wb_we_reg    <= 1'b0;
                            wb_rd_reg    <= req_rd_reg;
                            wb_data_reg  <= req_addr_reg;
                        end else begin
                            state_reg <= WAIT_RSP;
                        end
                    end else if (wait_last) begin
                        mem_req_reg  <= 1'b0;
                        state_reg    <= IDLE;
                        wb_valid_reg <= 1'b1;
                        wb_we_reg    <= 1'b0;
                        wb_rd_reg    <= req_rd_reg;
                        wb_data_reg  <= req_addr_reg;
                        exc_code_reg <= EXC_TIMEOUT;
                    end
                end
                WAIT_RSP: begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    if (mem_rvalid) begin
                        state_reg    <= IDLE;
                        wb_valid_reg <= 1'b1;
                        wb_we_reg    <= (req_rd_reg != 5'd0);
                        wb_rd_reg    <= req_rd_reg;
                        wb_data_reg  <= ld_data;
                    end else if (wait_last) begin
                        state_reg    <= IDLE;
                        wb_valid_reg <= 1'b1;
                        wb_we_reg    <= 1'b0;
                        wb_rd_reg    <= req_rd_reg;
                        wb_data_reg  <= req_addr_reg;
                        exc_code_reg <= EXC_TIMEOUT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ex_stall  = (state_reg != IDLE);
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_we     = wb_we_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;
    assign exc_code  = exc_code_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic        ex_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  exc_code;

    int checks;
    int failures;

    mem_stage_lsu #(.XLEN(32), .MAX_WAIT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_funct3     (ex_funct3),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_rd         (ex_rd),
        .ex_stall      (ex_stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .exc_code      (exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The bus model must never respond in the same cycle it grants.
    always @(posedge clk) begin
        assert (!(mem_gnt && mem_rvalid)) else $error("bus protocol: gnt and rvalid together");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, obs);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                            input logic rd_op, input logic wr_op, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_alu_result = addr;
        ex_store_data = sd;
        ex_funct3     = f3;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_rd         = rd;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Minimum-latency load: accept, gnt on first REQ cycle, rvalid on first WAIT_RSP cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        drive_ex(addr, 32'h0, f3, 1'b1, 1'b0, 5'd7);
        tick();
        idle_ex();
        chk({tag, ".req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, ".wb_we"}, {31'd0, wb_we}, 32'd1);
        chk({tag, ".wb_data"}, wb_data, exp_data);
        chk({tag, ".exc"}, {30'd0, exc_code}, 32'd0);
        tick();
    endtask

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        ex_alu_result = 32'h0;
        ex_store_data = 32'h0;
        ex_funct3  = 3'b000;
        ex_rd      = 5'd0;
        idle_ex();
        tick();
        tick();
        chk("rst.ex_stall", {31'd0, ex_stall}, 32'd0);
        chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst.exc", {30'd0, exc_code}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Non-memory op, latency 1
        drive_ex(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5);
        chk("alu.ex_stall", {31'd0, ex_stall}, 32'd0);
        tick();
        idle_ex();
        chk("alu.wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu.wb_we", {31'd0, wb_we}, 32'd1);
        chk("alu.wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("alu.wb_data", wb_data, 32'h0000_1234);
        tick();
        chk("alu.pulse_end", {31'd0, wb_valid}, 32'd0);
        chk("alu.wb_data_hold", wb_data, 32'h0000_1234);

        // SB 0x103, gnt on the fourth REQ cycle
        drive_ex(32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 5'd0);
        tick();
        idle_ex();
        chk("sb.mem_we", {31'd0, mem_we}, 32'd1);
        chk("sb.mem_addr", mem_addr, 32'h0000_0100);
        chk("sb.mem_be", {28'd0, mem_be}, 32'b1000);
        chk("sb.wdata_hi", {24'd0, mem_wdata[31:24]}, 32'h0000_00AB);
        n = 0;
        while (ex_stall && n < 20) begin
            n++;
            chk("sb.req_held", {31'd0, mem_req}, 32'd1);
            mem_gnt = (n == 4);
            tick();
        end
        mem_gnt = 1'b0;
        chk("sb.stall_cycles", n, 32'd4);
        chk("sb.wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sb.wb_we", {31'd0, wb_we}, 32'd0);
        chk("sb.mem_req_drop", {31'd0, mem_req}, 32'd0);
        tick();

        // Loads with lane select and extension
        do_load("lb",  32'h0000_0102, 3'b000, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_0102, 3'b100, 32'h0080_0000, 4'b0100, 32'h0000_0080);
        do_load("lh",  32'h0000_0102, 3'b001, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 32'h0000_0100, 3'b101, 32'h1234_F00F, 4'b0011, 32'h0000_F00F);
        do_load("lw",  32'h0000_0200, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned word load
        drive_ex(32'h0000_0101, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9);
        tick();
        idle_ex();
        chk("mis.mem_req", {31'd0, mem_req}, 32'd0);
        chk("mis.ex_stall", {31'd0, ex_stall}, 32'd0);
        chk("mis.wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("mis.wb_we", {31'd0, wb_we}, 32'd0);
        chk("mis.exc", {30'd0, exc_code}, 32'd1);
        chk("mis.wb_data", wb_data, 32'h0000_0101);
        tick();
        chk("mis.exc_clear", {30'd0, exc_code}, 32'd0);

        // Illegal funct3 on a load, and BU on a store
        drive_ex(32'h0000_0200, 32'h0, 3'b011, 1'b1, 1'b0, 5'd9);
        tick();
        idle_ex();
        chk("ill_ld.exc", {30'd0, exc_code}, 32'd3);
        chk("ill_ld.mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        drive_ex(32'h0000_0204, 32'h55, 3'b100, 1'b0, 1'b1, 5'd0);
        tick();
        idle_ex();
        chk("ill_st.exc", {30'd0, exc_code}, 32'd3);
        chk("ill_st.wb_data", wb_data, 32'h0000_0204);
        tick();

        // Timeout: granted load never answers
        drive_ex(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4);
        tick();
        idle_ex();
        n = 0;
        while (ex_stall && n < 50) begin
            n++;
            mem_gnt = (n == 1);
            tick();
        end
        mem_gnt = 1'b0;
        chk("tmo.cycles", n, 32'd8);
        chk("tmo.wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("tmo.wb_we", {31'd0, wb_we}, 32'd0);
        chk("tmo.exc", {30'd0, exc_code}, 32'd2);
        chk("tmo.wb_data", wb_data, 32'h0000_0300);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        chk("tmo.late_rvalid", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("tmo.late_rvalid2", {31'd0, wb_valid}, 32'd0);

        // Reset while in WAIT_RSP
        drive_ex(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6);
        tick();
        idle_ex();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rmt.in_wait", {31'd0, ex_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmt.ex_stall", {31'd0, ex_stall}, 32'd0);
        chk("rmt.mem_addr", mem_addr, 32'd0);
        chk("rmt.wb_data", wb_data, 32'd0);
        chk("rmt.wb_rd", {27'd0, wb_rd}, 32'd0);
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2222_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("rmt.no_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("rmt.no_wb2", {31'd0, wb_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
